pipeline_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage core (F/D/E/M/W). Replaces the current free-running pipeline registers with stall, flush and forward control.
- Detects RAW hazards, load-use hazards, taken branches/jumps resolved in M (PCSel), and multi-cycle data-memory accesses.
- Drives per-stage stall/flush enables and E-stage operand forward selects.
- Keeps saturating performance counters and a sticky memory-timeout error.

---
 rtl/pipeline_hazard_pkg.sv | 18 +
 rtl/fwd_select.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/forwarding controller.
package pipeline_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Bubble instruction (addi x0,x0,0) loaded by the datapath on a stage flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fwd_select.sv
// Per-operand E-stage bypass mux select: M result has priority over W data; x0 never bypasses.
module fwd_select
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwen_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwen_w_i,
  output fwd_sel_t          sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (FWD_EN) begin
      if (regwen_m_i && (rd_m_i == rs_e_i) && (rd_m_i != '0)) begin
        sel_o = FWD_MEM;
      end else if (regwen_w_i && (rd_w_i == rs_e_i) && (rd_w_i != '0)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the F/D/E/M/W core, with a data-memory wait FSM,
// saturating performance counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter bit FWD_EN   = 1'b1,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwen_e,
  input  logic              regwen_m,
  input  logic              regwen_w,
  input  logic              load_e,
  input  logic              load_m,
  input  logic              memop_m,
  input  logic              dmem_ack,
  input  logic              pcsel_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_timeout
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic     hit_e, hit_m, hit_w;
  logic     data_hz, mem_stall, redirect;
  fwd_sel_t fwd_a_raw, fwd_b_raw;

  // A used, non-zero D source matches the destination of a given stage.
  assign hit_e = (rd_e != '0) && ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
  assign hit_m = (rd_m != '0) && ((use_rs1_d && (rs1_d == rd_m)) || (use_rs2_d && (rs2_d == rd_m)));
  assign hit_w = (rd_w != '0) && ((use_rs1_d && (rs1_d == rd_w)) || (use_rs2_d && (rs2_d == rd_w)));

  always_comb begin
    data_hz = 1'b0;
    if (FWD_EN) begin
      data_hz = (load_e && regwen_e && hit_e)
             || (load_m && regwen_m && memop_m && !dmem_ack && hit_m);
    end else begin
      data_hz = (regwen_e && hit_e) || (regwen_m && hit_m) || (regwen_w && hit_w);
    end
  end

  // The first un-acked cycle of an access stalls too, so every cycle without ack is a wait cycle.
  assign mem_stall = ((state_q == MEM_WAIT) || memop_m) && !dmem_ack;
  assign redirect  = pcsel_m && !mem_stall;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
      end else if (data_hz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  fwd_select #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
    .rs_e_i     (rs1_e),
    .rd_m_i     (rd_m),
    .regwen_m_i (regwen_m),
    .rd_w_i     (rd_w),
    .regwen_w_i (regwen_w),
    .sel_o      (fwd_a_raw)
  );

  fwd_select #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
    .rs_e_i     (rs2_e),
    .rd_m_i     (rd_m),
    .regwen_m_i (regwen_m),
    .rd_w_i     (rd_w),
    .regwen_w_i (regwen_w),
    .sel_o      (fwd_b_raw)
  );

  assign fwd_a_sel = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b_sel = rst ? FWD_RF : fwd_b_raw;

  // After a timeout the FSM still waits in MEM_WAIT; a late ack is allowed to resume the core.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (memop_m && !dmem_ack) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (mem_stall) begin
      wait_d = (wait_q == WAIT_W'(WAIT_MAX)) ? wait_q : wait_q + 1'b1;
      if (wait_q == WAIT_W'(WAIT_MAX - 1)) timeout_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a forwarding build and a no-forwarding build with a 2-bit counter share stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       use_rs1_d, use_rs2_d, regwen_e, regwen_m, regwen_w;
  logic       load_e, load_m, memop_m, dmem_ack, pcsel_m;

  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  logic        stall_f0, stall_d0, stall_e0, stall_m0, flush_d0, flush_e0, flush_m0, flush_w0;
  logic [1:0]  fwd_a_sel0, fwd_b_sel0;
  logic [1:0]  stall_cnt0, flush_cnt0;
  logic        mem_timeout0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .WAIT_MAX(15), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwen_e(regwen_e), .regwen_m(regwen_m), .regwen_w(regwen_w),
    .load_e(load_e), .load_m(load_m), .memop_m(memop_m), .dmem_ack(dmem_ack), .pcsel_m(pcsel_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .WAIT_MAX(15), .CNT_W(2)) u_dut_nofwd (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwen_e(regwen_e), .regwen_m(regwen_m), .regwen_w(regwen_w),
    .load_e(load_e), .load_m(load_m), .memop_m(memop_m), .dmem_ack(dmem_ack), .pcsel_m(pcsel_m),
    .stall_f(stall_f0), .stall_d(stall_d0), .stall_e(stall_e0), .stall_m(stall_m0),
    .flush_d(flush_d0), .flush_e(flush_e0), .flush_m(flush_m0), .flush_w(flush_w0),
    .fwd_a_sel(fwd_a_sel0), .fwd_b_sel(fwd_b_sel0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0), .mem_timeout(mem_timeout0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clr();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    use_rs1_d = 1'b0; use_rs2_d = 1'b0;
    regwen_e = 1'b0; regwen_m = 1'b0; regwen_w = 1'b0;
    load_e = 1'b0; load_m = 1'b0; memop_m = 1'b0; dmem_ack = 1'b0; pcsel_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    tick();
    tick();

    // Outputs forced quiet while reset is held, even with hazards present
    memop_m = 1'b1; pcsel_m = 1'b1; regwen_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
    #1;
    check("rst_stalls", {28'd0, stall_f, stall_d, stall_e, stall_m}, 32'h0);
    check("rst_flushes", {28'd0, flush_d, flush_e, flush_m, flush_w}, 32'h0);
    check("rst_fwd_a", {30'd0, fwd_a_sel}, 32'h0);
    check("rst_cnt", {16'd0, stall_cnt}, 32'h0);
    check("rst_timeout", {31'd0, mem_timeout}, 32'h0);
    clr();
    tick();
    rst = 1'b0;

    // add x5 in M, sub x6,x5,x3 in E
    regwen_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd3;
    #1;
    check("fwd_a_mem", {30'd0, fwd_a_sel}, 32'h1);
    check("fwd_b_none", {30'd0, fwd_b_sel}, 32'h0);
    check("fwd_nostall", {31'd0, stall_f}, 32'h0);
    check("nofwd_sel", {30'd0, fwd_a_sel0}, 32'h0);
    regwen_m = 1'b0; regwen_w = 1'b1; rd_w = 5'd5; rs2_e = 5'd5;
    #1;
    check("fwd_a_wb", {30'd0, fwd_a_sel}, 32'h2);
    check("fwd_b_wb", {30'd0, fwd_b_sel}, 32'h2);
    regwen_m = 1'b1; rd_m = 5'd5;
    #1;
    check("fwd_m_prio", {30'd0, fwd_a_sel}, 32'h1);
    rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    #1;
    check("fwd_x0", {28'd0, fwd_a_sel, fwd_b_sel}, 32'h0);
    clr();

    // Load-use: lw x7 in E, add x8,x7,x2 in D
    do_reset();
    load_e = 1'b1; regwen_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; rs2_d = 5'd2;
    use_rs1_d = 1'b1; use_rs2_d = 1'b1;
    #1;
    check("lu_stall", {28'd0, stall_f, stall_d, flush_e, flush_d}, 32'he);
    tick();
    load_e = 1'b0; regwen_e = 1'b0; rd_e = 5'd0;
    load_m = 1'b1; memop_m = 1'b1; dmem_ack = 1'b1; regwen_m = 1'b1; rd_m = 5'd7;
    #1;
    check("lu_release", {29'd0, stall_f, stall_d, flush_e}, 32'h0);
    check("lu_cnt", {16'd0, stall_cnt}, 32'h1);
    tick();
    clr();
    regwen_w = 1'b1; rd_w = 5'd7; rs1_e = 5'd7; rs2_e = 5'd2;
    #1;
    check("lu_fwd_wb", {30'd0, fwd_a_sel}, 32'h2);
    check("lu_fwd_b", {30'd0, fwd_b_sel}, 32'h0);
    check("lu_nostall", {31'd0, stall_f}, 32'h0);
    clr();
    load_e = 1'b1; regwen_e = 1'b1; rd_e = 5'd9; rs2_d = 5'd9; use_rs2_d = 1'b0;
    #1;
    check("lu_unused_rs", {31'd0, stall_f}, 32'h0);
    clr();

    // Memory wait: ack held low for three cycles
    do_reset();
    memop_m = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_stall%0d", i), {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h1f);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    check("mw_ack_run", {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h0);
    check("mw_cnt", {16'd0, stall_cnt}, 32'h3);
    tick();
    clr();
    #1;
    check("mw_after", {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h0);

    // Redirect beats a simultaneous load-use hazard
    do_reset();
    pcsel_m = 1'b1; load_e = 1'b1; regwen_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; use_rs1_d = 1'b1;
    #1;
    check("rd_flush", {28'd0, flush_d, flush_e, flush_m, flush_w}, 32'he);
    check("rd_nostall", {30'd0, stall_f, stall_d}, 32'h0);
    tick();
    clr();
    #1;
    check("rd_fcnt", {16'd0, flush_cnt}, 32'h1);
    check("rd_scnt", {16'd0, stall_cnt}, 32'h0);
    memop_m = 1'b1; pcsel_m = 1'b1;
    #1;
    check("rd_in_wait", {27'd0, stall_f, flush_d, flush_e, flush_m, flush_w}, 32'h11);
    tick();
    dmem_ack = 1'b1;
    #1;
    check("rd_on_ack", {27'd0, stall_f, flush_d, flush_e, flush_m, flush_w}, 32'he);
    tick();
    clr();
    #1;
    check("rd_fcnt2", {16'd0, flush_cnt}, 32'h2);

    // Timeout after the 15th wait cycle, cleared by reset
    do_reset();
    memop_m = 1'b1; dmem_ack = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14 || i == 15 || i == 20)
        check($sformatf("to_after%0d", i), {31'd0, mem_timeout}, (i >= 15) ? 32'h1 : 32'h0);
    end
    rst = 1'b1;
    #1;
    check("to_rst_out", {24'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}, 32'h0);
    tick();
    rst = 1'b0;
    clr();
    #1;
    check("to_cleared", {31'd0, mem_timeout}, 32'h0);
    check("to_run", {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h0);
    check("to_cnt", {16'd0, stall_cnt}, 32'h0);

    // No-forwarding build: producer x4 in W, consumer in D
    do_reset();
    regwen_w = 1'b1; rd_w = 5'd4; rs1_d = 5'd4; use_rs1_d = 1'b1; rs1_e = 5'd4;
    #1;
    check("nf_stall", {29'd0, stall_f0, stall_d0, flush_e0}, 32'h7);
    check("nf_sel", {28'd0, fwd_a_sel0, fwd_b_sel0}, 32'h0);
    check("fw_nostall", {31'd0, stall_f}, 32'h0);
    check("fw_sel_wb", {30'd0, fwd_a_sel}, 32'h2);
    tick();
    regwen_w = 1'b0;
    #1;
    check("nf_release", {31'd0, stall_f0}, 32'h0);
    check("nf_cnt1", {30'd0, stall_cnt0}, 32'h1);
    regwen_w = 1'b1;
    tick();
    check("nf_cnt2", {30'd0, stall_cnt0}, 32'h2);
    tick();
    check("nf_cnt_max", {30'd0, stall_cnt0}, 32'h3);
    tick();
    check("nf_cnt_sat", {30'd0, stall_cnt0}, 32'h3);
    clr();
    regwen_w = 1'b1; rd_w = 5'd0; rs1_d = 5'd0; use_rs1_d = 1'b1;
    #1;
    check("nf_x0", {31'd0, stall_f0}, 32'h0);
    clr();
    regwen_e = 1'b1; rd_e = 5'd6; rs2_d = 5'd6; use_rs2_d = 1'b1;
    #1;
    check("nf_e_raw", {31'd0, stall_f0}, 32'h1);
    check("fw_e_alu", {31'd0, stall_f}, 32'h0);
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
